viol_reset_ctrl: RTL
====================

// Module: viol_reset_ctrl
// PURPOSE
//  Sits directly downstream of the active-RoT access-control monitors (DMA key-memory monitor, PC/code monitors).
//  Merges their per-monitor reset requests into one system reset.
//  - Stretches that reset to a guaranteed minimum width.
//  - Latches a sticky cause bitmap and keeps a saturating violation count.
//  - Re-arms only after the CPU is seen fetching from the reset handler.
// PARAMETERS
//  N_SRC          4        number of monitor request inputs (>=1)
//  MIN_RST_CYCLES 8        minimum sys_rst high width in clk cycles (>=1)
//  CNT_W          8        width of violation counter
//  RESET_HANDLER  16'h0000 PC value that re-arms the block
// PORTS
//  clk        in   1      system clock; single clock domain
//  rst_n      in   1      reset, synchronous, active-low
//  pc         in   16     current CPU program counter
//  viol_req   in   N_SRC  per-monitor reset request, level, active-high (bit0 = DMA key-mem monitor)
//  cause_clr  in   1      one-cycle pulse: clear cause bitmap
//  sys_rst    out  1      registered system reset, active-high
//  armed      out  1      1 = IDLE, monitoring for new violations
//  cause      out  N_SRC  sticky bitmap of sources that triggered reset
//  viol_count out  CNT_W  saturating count of violation events
// BEHAVIOUR
//  Reset (rst_n=0 at posedge):
//   - state=WAIT_RH; sys_rst=0, armed=0, cause=0, viol_count=0.
//   - prev_req <= viol_req, so levels already high at reset release are not treated as events.
//  Event detection:
//   - edge[i] = viol_req[i] & ~prev_req[i]; prev_req registered every cycle.
//   - event = |edge. Monitor request levels are never events on their own; only rising edges are.
//  FSM states: IDLE, ASSERT, WAIT_RH.
//   - IDLE: sys_rst=0, armed=1. On event: go to ASSERT, load rst_cnt=MIN_RST_CYCLES-1.
//   - ASSERT: sys_rst=1.
//       * Event: reload rst_cnt=MIN_RST_CYCLES-1 (retrigger; stay in ASSERT).
//       * Else if rst_cnt==0: go to WAIT_RH.
//       * Else: rst_cnt--.
//   - WAIT_RH: sys_rst=0, armed=0.
//       * Event (checked first): go to ASSERT with reload.
//       * Else if pc==RESET_HANDLER: go to IDLE.
//  Timing:
//   - sys_rst rises 1 cycle after the edge cycle.
//   - sys_rst stays high exactly MIN_RST_CYCLES cycles after the last event.
//  Cause and count update on every event cycle, in any state:
//   - cause |= edge.
//   - viol_count += 1, once per cycle regardless of how many bits are in edge; saturates at all-ones.
//  cause_clr:
//   - Alone: cause <= 0.
//   - Same cycle as an event: cause <= edge (the new event wins over the clear).
//  Simultaneous edges on several sources: one event, all their bits set in cause.
//  rst_n low mid-ASSERT: sys_rst drops on that clock edge; cause and count are cleared.
// STRUCTURE
//  Shared package (acfa_rot_pkg):
//   - state encodings IDLE/ASSERT/WAIT_RH.
//   - RESET_HANDLER constant.
//   - source index constants SRC_DMA=0, SRC_PC=1, SRC_STACK=2, SRC_CFLOG=3.
//  Sub-module viol_edge_det:
//   - N_SRC-wide prev_req register plus edge/event generation.
//   - clk, rst_n, viol_req -> edge, event.
//  Everything else (FSM, rst_cnt, cause, viol_count) lives in this module.
// TESTING
//  1. rst_n low 2 cycles, then pc=0x0000
//     -> sys_rst=0, armed=1 one cycle later, cause=0, count=0.
//  2. viol_req[0] rises at cycle t in IDLE
//     -> sys_rst=1 for cycles t+1..t+8, cause=4'b0001, count=1.
//     Then pc=0x0000 -> armed=1.
//  3. Bits 1 and 2 rise in the same cycle
//     -> single event: count+=1, cause=4'b0110.
//  4. Bit0 rises, then bit3 rises 5 cycles later
//     -> sys_rst held until 8 cycles after the bit3 edge (13 high cycles total), count+=2.
//  5. 256 events with CNT_W=8 -> viol_count saturates at 8'hFF.
//     cause_clr together with a bit2 edge -> cause=4'b0100.
//  6. viol_req held high through the rst_n release, then pc=0x0000
//     -> no event, armed=1, count=0.
//     rst_n pulsed low mid-ASSERT -> sys_rst=0 next cycle.

Source files
------------

// File: rtl/acfa_rot_pkg.sv
// Shared definitions for the RoT access-control blocks: reset-controller
// state encoding, reset-handler address and monitor source indices.
package acfa_rot_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_WAIT_RH = 2'd2
    } rst_state_e;

    localparam logic [15:0] RESET_HANDLER_PC = 16'h0000;

    localparam int SRC_DMA   = 0;
    localparam int SRC_PC    = 1;
    localparam int SRC_STACK = 2;
    localparam int SRC_CFLOG = 3;

endpackage

// File: rtl/viol_edge_det.sv
// Rising-edge detector for the monitor reset requests; a level that is
// already high when reset releases never produces an edge.
module viol_edge_det #(
    parameter int N_SRC = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SRC-1:0] viol_req,
    output logic [N_SRC-1:0] edges,
    output logic             evt
);

    logic [N_SRC-1:0] prev_req;

    // Captured in and out of reset so held levels are absorbed at release.
    always_ff @(posedge clk) begin
        prev_req <= viol_req;
    end

    assign edges = viol_req & ~prev_req & {N_SRC{rst_n}};
    assign evt   = |edges;

endmodule

// File: rtl/viol_reset_ctrl.sv
// Merges monitor violation requests into a stretched system reset with a
// sticky cause bitmap, saturating violation count and reset-handler re-arm.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | armed, sys_rst low, watching for a new violation edge
// ST_ASSERT  | sys_rst high, rst_cnt counts down the minimum width
// ST_WAIT_RH | sys_rst low, waiting for the CPU to fetch the reset handler
module viol_reset_ctrl
    import acfa_rot_pkg::*;
#(
    parameter int          N_SRC          = 4,
    parameter int          MIN_RST_CYCLES = 8,
    parameter int          CNT_W          = 8,
    parameter logic [15:0] RESET_HANDLER  = RESET_HANDLER_PC
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      pc,
    input  logic [N_SRC-1:0] viol_req,
    input  logic             cause_clr,
    output logic             sys_rst,
    output logic             armed,
    output logic [N_SRC-1:0] cause,
    output logic [CNT_W-1:0] viol_count
);

    localparam int RC_W = (MIN_RST_CYCLES > 1) ? $clog2(MIN_RST_CYCLES) : 1;
    localparam logic [RC_W-1:0] RC_LOAD = RC_W'(MIN_RST_CYCLES - 1);

    rst_state_e       state, state_nxt;
    logic [RC_W-1:0]  rst_cnt, rst_cnt_nxt;
    logic             sys_rst_nxt, armed_nxt;
    logic [N_SRC-1:0] edges;
    logic             evt;

    viol_edge_det #(.N_SRC(N_SRC)) u_edge_det (
        .clk      (clk),
        .rst_n    (rst_n),
        .viol_req (viol_req),
        .edges    (edges),
        .evt      (evt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_WAIT_RH;
            rst_cnt <= '0;
            sys_rst <= 1'b0;
            armed   <= 1'b0;
        end else begin
            state   <= state_nxt;
            rst_cnt <= rst_cnt_nxt;
            sys_rst <= sys_rst_nxt;
            armed   <= armed_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        rst_cnt_nxt = rst_cnt;
        case (state)
            ST_IDLE: begin
                if (evt) begin
                    state_nxt   = ST_ASSERT;
                    rst_cnt_nxt = RC_LOAD;
                end
            end
            ST_ASSERT: begin
                if (evt) begin
                    rst_cnt_nxt = RC_LOAD;
                end else if (rst_cnt == '0) begin
                    state_nxt = ST_WAIT_RH;
                end else begin
                    rst_cnt_nxt = rst_cnt - 1'b1;
                end
            end
            ST_WAIT_RH: begin
                if (evt) begin
                    state_nxt   = ST_ASSERT;
                    rst_cnt_nxt = RC_LOAD;
                end else if (pc == RESET_HANDLER) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_WAIT_RH;
            end
        endcase
    end

    // Outputs are decoded from the next state so they leave a flop directly.
    always_comb begin
        sys_rst_nxt = (state_nxt == ST_ASSERT);
        armed_nxt   = (state_nxt == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cause      <= '0;
            viol_count <= '0;
        end else begin
            if (evt) begin
                cause <= cause_clr ? edges : (cause | edges);
            end else if (cause_clr) begin
                cause <= '0;
            end
            if (evt && (viol_count != {CNT_W{1'b1}})) begin
                viol_count <= viol_count + 1'b1;
            end
        end
    end

endmodule
